// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display path.
// Digit index constants locate each BCD digit on the 16-bit digit bus.
package seg7_pkg;

    localparam int BCD_W       = 4;
    localparam int SAT_MAX_DEF = 99;

    localparam int DIG_LO_UNITS = 0;
    localparam int DIG_LO_TENS  = 1;
    localparam int DIG_HI_UNITS = 2;
    localparam int DIG_HI_TENS  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dabble_byte.sv
// Double-dabble engine for one binary operand (input clamped to SAT_MAX).
// Ports: clk, clr (sync reset), load/din (latch operand), step (one
// add-3/shift iteration), digits {tens,units}, sat (operand was clamped).
module dabble_byte
    import seg7_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int SAT_MAX = SAT_MAX_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              step,
    input  logic [IN_W-1:0]   din,
    output logic [2*BCD_W-1:0] digits,
    output logic              sat
);

    // Three nibbles: units, tens, hundreds. Hundreds stays internal.
    localparam int NIB  = 3;
    localparam int SR_W = NIB * BCD_W + IN_W;
    localparam logic [IN_W-1:0] SAT_V = IN_W'(SAT_MAX);

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] adj;
    logic [IN_W-1:0] clamped;

    assign clamped = (din > SAT_V) ? SAT_V : din;

    always_comb begin
        adj = sr;
        for (int i = 0; i < NIB; i++) begin
            if (adj[IN_W + i*BCD_W +: BCD_W] >= 4'd5) begin
                adj[IN_W + i*BCD_W +: BCD_W] =
                    adj[IN_W + i*BCD_W +: BCD_W] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sr  <= '0;
            sat <= 1'b0;
        end else if (load) begin
            sr  <= {{(NIB*BCD_W){1'b0}}, clamped};
            sat <= (din > SAT_V);
        end else if (step) begin
            sr  <= {adj[SR_W-2:0], 1'b0};
        end
    end

    assign digits = sr[IN_W +: 2*BCD_W];

endmodule

// File: rtl/bcd_pair_converter.sv
// Converts two binary bytes to four packed BCD digits for the display.
// Ports: clk, clr (sync reset), twonum/in_valid/in_ready (request),
// bcd_num/ovf (held result), out_valid (one-cycle update pulse).
// Macro AUTO_UPDATE_EN: self-start whenever twonum differs from the
// last accepted value; in_valid is then ignored.
module bcd_pair_converter
    import seg7_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int SAT_MAX = SAT_MAX_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [2*IN_W-1:0] twonum,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       bcd_num,
    output logic              out_valid,
    output logic [1:0]        ovf
);

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_W - 1);

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0] cnt;
    logic go;
    logic start;
    logic step;
    logic done;

    logic [2*BCD_W-1:0] lo_dig;
    logic [2*BCD_W-1:0] hi_dig;
    logic lo_sat;
    logic hi_sat;

`ifdef AUTO_UPDATE_EN
    logic [2*IN_W-1:0] copy;
    logic unused_in_valid;

    assign unused_in_valid = in_valid;
    assign go = (twonum != copy);

    always_ff @(posedge clk) begin
        if (clr) begin
            copy <= '0;
        end else if (start) begin
            copy <= twonum;
        end
    end
`else
    assign go = in_valid;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    start      = 1'b1;
                    next_state = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    dabble_byte #(.IN_W(IN_W), .SAT_MAX(SAT_MAX)) u_lo (
        .clk    (clk),
        .clr    (clr),
        .load   (start),
        .step   (step),
        .din    (twonum[IN_W-1:0]),
        .digits (lo_dig),
        .sat    (lo_sat)
    );

    dabble_byte #(.IN_W(IN_W), .SAT_MAX(SAT_MAX)) u_hi (
        .clk    (clk),
        .clr    (clr),
        .load   (start),
        .step   (step),
        .din    (twonum[2*IN_W-1:IN_W]),
        .digits (hi_dig),
        .sat    (hi_sat)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            bcd_num   <= '0;
            ovf       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= done;
            if (done) begin
                bcd_num[DIG_LO_UNITS*BCD_W +: 2*BCD_W] <= lo_dig;
                bcd_num[DIG_HI_UNITS*BCD_W +: 2*BCD_W] <= hi_dig;
                ovf <= {hi_sat, lo_sat};
            end
        end
    end

    assign in_ready = (state == IDLE);

endmodule

// File: tb/tb_bcd_pair_converter.sv
// Self-checking bench for bcd_pair_converter (randomised, reference model).
// Build with AUTO_UPDATE_EN defined to exercise the self-start mode.
module tb_bcd_pair_converter;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] twonum = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] bcd_num;
    logic        out_valid;
    logic [1:0]  ovf;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    bcd_pair_converter dut (
        .clk       (clk),
        .clr       (clr),
        .twonum    (twonum),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_num   (bcd_num),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    function automatic logic [7:0] ref_pair(input logic [7:0] v);
        int c;
        logic [3:0] t;
        logic [3:0] u;
        c = (v > 99) ? 99 : int'(v);
        t = 4'(c / 10);
        u = 4'(c % 10);
        return {t, u};
    endfunction

    function automatic logic [15:0] ref_bcd(input logic [15:0] v);
        return {ref_pair(v[15:8]), ref_pair(v[7:0])};
    endfunction

    function automatic logic [1:0] ref_ovf(input logic [15:0] v);
        return {v[15:8] > 8'd99, v[7:0] > 8'd99};
    endfunction

    function automatic logic [15:0] rand_val();
        logic [7:0] a;
        logic [7:0] b;
        a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 99))
                                        : 8'($urandom_range(0, 255));
        b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 99))
                                        : 8'($urandom_range(0, 255));
        return {a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) tick();
        clr = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || bcd_num !== 16'h0000 ||
            out_valid !== 1'b0 || ovf !== 2'b00) begin
            errors++;
            $display("FAIL reset: rdy=%b bcd=%h ov=%b ovf=%b, want 1 0000 0 00",
                     in_ready, bcd_num, out_valid, ovf);
        end
    endtask

    // Wait for the result after an accept edge; checks latency and hold.
    task automatic wait_result(input logic [15:0] t,
                               input logic [15:0] old_bcd,
                               input logic [1:0]  old_ovf);
        bit got = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if (out_valid === 1'b1) begin
                got = 1;
                vectors++;
                if (c != 9 || bcd_num !== ref_bcd(t) || ovf !== ref_ovf(t)) begin
                    errors++;
                    $display("FAIL result %h: lat=%0d bcd=%h ovf=%b, want 9 %h %b",
                             t, c, bcd_num, ovf, ref_bcd(t), ref_ovf(t));
                end
            end else begin
                vectors++;
                if (bcd_num !== old_bcd || ovf !== old_ovf || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy %h c=%0d: bcd=%h ovf=%b rdy=%b, want %h %b 0",
                             t, c, bcd_num, ovf, in_ready, old_bcd, old_ovf);
                end
            end
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL timeout %h: no out_valid within 20 clocks", t);
        end
    endtask

`ifndef AUTO_UPDATE_EN
    task automatic convert(input logic [15:0] t);
        logic [15:0] ob;
        logic [1:0]  oo;
        for (int n = 0; n < 20 && in_ready !== 1'b1; n++) tick();
        ob = bcd_num;
        oo = ovf;
        twonum   = t;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(t, ob, oo);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pulse %h: ov=%b rdy=%b, want 0 1", t, out_valid, in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] fixed [7];
        fixed = '{16'h0C2A, 16'h6300, 16'hFF64, 16'h0000,
                  16'h6363, 16'h6464, 16'h0A63};
        foreach (fixed[i]) convert(fixed[i]);
        for (int i = 0; i < 20; i++) convert(rand_val());
    endtask

    task automatic test_stream();
        logic [15:0] exp_q [$];
        int acc_q [$];
        int last_acc = -1;
        logic [15:0] held;
        logic pre;
        held = bcd_num;
        in_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            twonum = rand_val();
            pre = in_ready;
            tick();
            if (pre) begin
                exp_q.push_back(twonum);
                acc_q.push_back(c);
                if (last_acc >= 0) begin
                    vectors++;
                    if (c - last_acc != 10) begin
                        errors++;
                        $display("FAIL stream spacing: %0d, want 10", c - last_acc);
                    end
                end
                last_acc = c;
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream extra pulse: bcd=%h, want none", bcd_num);
                end else begin
                    if (bcd_num !== ref_bcd(exp_q[0]) || c - acc_q[0] != 9) begin
                        errors++;
                        $display("FAIL stream result: bcd=%h lat=%0d, want %h 9",
                                 bcd_num, c - acc_q[0], ref_bcd(exp_q[0]));
                    end
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
                held = bcd_num;
            end else if (bcd_num !== held) begin
                vectors++;
                errors++;
                $display("FAIL stream hold: bcd=%h, want %h", bcd_num, held);
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream drain: rdy=%b, want 1", in_ready);
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        convert(16'h2B4D);
        twonum   = 16'h5817;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || bcd_num !== 16'h0 || ovf !== 2'b00 ||
            out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort: rdy=%b bcd=%h ovf=%b ov=%b, want 1 0000 00 0",
                     in_ready, bcd_num, ovf, out_valid);
        end
        clr      = 1'b1;
        in_valid = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid === 1'b1) seen = 1;
        end
        vectors++;
        if (seen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort pulse: seen=%0d rdy=%b, want 0 1", seen, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] ob;
        logic [1:0]  oo;
        a  = rand_val();
        b  = rand_val();
        ob = bcd_num;
        oo = ovf;
        twonum   = a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(a, ob, oo);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b ready: rdy=%b, want 1", in_ready);
        end
        twonum   = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(b, ref_bcd(a), ref_ovf(a));
    endtask
`else
    task automatic auto_wait(input logic [15:0] t);
        logic [15:0] ob;
        logic [1:0]  oo;
        ob = bcd_num;
        oo = ovf;
        twonum = t;
        wait_result(t, ob, oo);
    endtask

    task automatic test_auto();
        bit seen = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid === 1'b1) seen = 1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL auto idle: pulse seen with static 0000, want none");
        end
        in_valid = 1'b0;
        auto_wait(16'h0105);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (out_valid === 1'b1) seen = 1;
        end
        vectors++;
        if (seen || bcd_num !== 16'h0105) begin
            errors++;
            $display("FAIL auto static: seen=%0d bcd=%h, want 0 0105", seen, bcd_num);
        end
        auto_wait(16'hFF64);
        tick();
        for (int i = 0; i < 15; i++) begin
            auto_wait(rand_val() | 16'h0001);
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUTO_UPDATE_EN
        test_auto();
`else
        test_vectors();
        test_stream();
        test_abort();
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
